// File: rtl/greycode_receiver.sv
// Grey-coded count receiver.
// Carries a grey count through a capture chain, decodes it to binary, and
// checks that each accepted value either repeats the previous one or steps
// by +1 (mod 2^WIDTH). Reports advance pulses, skip pulses and a sticky error.
module greycode_receiver #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_grey,
    input  logic             in_valid,
    input  logic             err_clr,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_valid,
    output logic             advance,
    output logic             step_err,
    output logic             err_sticky
);

    typedef enum logic [1:0] {
        ST_UNPRIMED,
        ST_TRACKING,
        ST_ERROR
    } state_e;

    // Each stage holds {valid, grey}.
    logic [WIDTH:0]   chain_q [SYNC_STAGES];

    state_e           state_q,      state_d;
    logic [WIDTH-1:0] out_bin_q,    out_bin_d;
    logic             out_valid_q,  out_valid_d;
    logic             advance_q,    advance_d;
    logic             step_err_q,   step_err_d;
    logic             err_sticky_q, err_sticky_d;

    logic             smp_valid;
    logic [WIDTH-1:0] smp_grey;
    logic [WIDTH-1:0] smp_bin;
    logic [WIDTH-1:0] delta;

    // Capture chain: shifts every cycle; reset flushes samples in flight.
    always_ff @(posedge clk) begin
        // NOTE: the chain is cleared on reset so stale samples are never decoded.
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage shift in parallel.
            chain_q[0] <= {in_valid, in_grey};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign smp_valid = chain_q[SYNC_STAGES-1][WIDTH];
    assign smp_grey  = chain_q[SYNC_STAGES-1][WIDTH-1:0];

    // Grey to binary: each binary bit is the XOR of all grey bits at or above it.
    always_comb begin
        smp_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            smp_bin[i] = ^(smp_grey >> i);
        end
    end

    // Wrapping difference against the last accepted value.
    assign delta = smp_bin - out_bin_q;

    // Tracker next-state and registered outputs; err_clr outranks the step check.
    always_comb begin
        // NOTE: every target gets a default first so no latch is inferred.
        state_d      = state_q;
        out_bin_d    = out_bin_q;
        out_valid_d  = out_valid_q;
        advance_d    = 1'b0;
        step_err_d   = 1'b0;
        err_sticky_d = err_sticky_q;

        if (err_clr) begin
            err_sticky_d = 1'b0;
            state_d      = ST_UNPRIMED;
            if (smp_valid) begin
                out_bin_d   = smp_bin;
                out_valid_d = 1'b1;
                state_d     = ST_TRACKING;
            end
        end else if (smp_valid) begin
            unique case (state_q)
                ST_UNPRIMED: begin
                    out_bin_d   = smp_bin;
                    out_valid_d = 1'b1;
                    state_d     = ST_TRACKING;
                end
                ST_TRACKING: begin
                    if (delta == WIDTH'(1)) begin
                        out_bin_d = smp_bin;
                        advance_d = 1'b1;
                    end else if (delta != '0) begin
                        out_bin_d    = smp_bin;
                        step_err_d   = 1'b1;
                        err_sticky_d = 1'b1;
                        state_d      = ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    out_bin_d = smp_bin;
                end
                default: begin
                    state_d = ST_UNPRIMED;
                end
            endcase
        end
    end

    // Tracker state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_UNPRIMED;
            out_bin_q    <= '0;
            out_valid_q  <= 1'b0;
            advance_q    <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_bin_q    <= out_bin_d;
            out_valid_q  <= out_valid_d;
            advance_q    <= advance_d;
            step_err_q   <= step_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign out_bin    = out_bin_q;
    assign out_valid  = out_valid_q;
    assign advance    = advance_q;
    assign step_err   = step_err_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_greycode_receiver.sv
// Directed bench for greycode_receiver (WIDTH=32, SYNC_STAGES=2).
// Each row gives the inputs sampled at one edge and the outputs expected right
// after that edge; the expected part goes into a queue that a monitor drains.
module tb_greycode_receiver;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_grey = '0;
    logic             in_valid = 1'b0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] out_bin;
    logic             out_valid;
    logic             advance;
    logic             step_err;
    logic             err_sticky;

    greycode_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_grey    (in_grey),
        .in_valid   (in_valid),
        .err_clr    (err_clr),
        .out_bin    (out_bin),
        .out_valid  (out_valid),
        .advance    (advance),
        .step_err   (step_err),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] bin;
        logic             ov;
        logic             adv;
        logic             se;
        logic             st;
    } exp_t;

    typedef struct packed {
        logic             rst;
        logic             vld;
        logic [WIDTH-1:0] grey;
        logic             clr;
        exp_t             e;
    } vec_t;

    typedef struct {
        int   due;
        int   row;
        exp_t e;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   n_edges = 0;
    int   checks  = 0;
    int   errors  = 0;

    always @(posedge clk) n_edges <= n_edges + 1;

    task automatic add(input logic r, input logic v, input logic [WIDTH-1:0] g,
                       input logic c, input logic [WIDTH-1:0] b, input logic ov,
                       input logic adv, input logic se, input logic st);
        vec_t x;
        x.rst = r; x.vld = v; x.grey = g; x.clr = c;
        x.e.bin = b; x.e.ov = ov; x.e.adv = adv; x.e.se = se; x.e.st = st;
        vecs.push_back(x);
    endtask

    // Monitor: compares every expected entry that falls due after this edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= n_edges) begin
            sb_t  s;
            exp_t got;
            s = sb_q.pop_front();
            got = '{bin: out_bin, ov: out_valid, adv: advance, se: step_err, st: err_sticky};
            checks++;
            if (s.due != n_edges || got !== s.e) begin
                errors++;
                $display("FAIL row%0d: got bin=%h ov=%b adv=%b se=%b st=%b, want bin=%h ov=%b adv=%b se=%b st=%b",
                         s.row, got.bin, got.ov, got.adv, got.se, got.st,
                         s.e.bin, s.e.ov, s.e.adv, s.e.se, s.e.st);
            end
        end
    end

    initial begin
        // rst v grey clr | bin ov adv se st   (outputs after that row's edge)
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0); // 0  reset
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0); // 1  reset
        add(0, 1, 32'h7,        0, 32'h0,        0, 0, 0, 0); // 2  bin 5
        add(0, 1, 32'h5,        0, 32'h0,        0, 0, 0, 0); // 3  bin 6
        add(0, 1, 32'h4,        0, 32'h5,        1, 0, 0, 0); // 4  bin 7; prime 5
        add(0, 0, 32'h0,        0, 32'h6,        1, 1, 0, 0); // 5  advance 6
        add(0, 0, 32'h0,        0, 32'h7,        1, 1, 0, 0); // 6  advance 7
        add(0, 1, 32'h4,        0, 32'h7,        1, 0, 0, 0); // 7  repeat 7
        add(0, 0, 32'hD,        0, 32'h7,        1, 0, 0, 0); // 8  invalid skip value
        add(0, 1, 32'h4,        0, 32'h7,        1, 0, 0, 0); // 9  repeat 7
        add(0, 0, 32'h0,        0, 32'h7,        1, 0, 0, 0); // 10 hold row7
        add(0, 1, 32'hC,        0, 32'h7,        1, 0, 0, 0); // 11 bin 8; row8 ignored
        add(0, 0, 32'h0,        0, 32'h7,        1, 0, 0, 0); // 12 hold row9
        add(0, 0, 32'h0,        0, 32'h8,        1, 1, 0, 0); // 13 advance 8
        add(0, 1, 32'h1E,       0, 32'h8,        1, 0, 0, 0); // 14 bin 20 (skip)
        add(0, 1, 32'hC,        0, 32'h8,        1, 0, 0, 0); // 15 bin 8
        add(0, 0, 32'h0,        0, 32'd20,       1, 0, 1, 1); // 16 step_err
        add(0, 0, 32'h0,        0, 32'h8,        1, 0, 0, 1); // 17 error: load, no pulse
        add(0, 1, 32'hD,        0, 32'h8,        1, 0, 0, 1); // 18 bin 9
        add(0, 0, 32'h0,        0, 32'h8,        1, 0, 0, 1); // 19
        add(0, 0, 32'h0,        0, 32'h9,        1, 0, 0, 1); // 20 +1 in error: no advance
        add(0, 1, 32'h1E,       0, 32'h9,        1, 0, 0, 1); // 21 bin 20
        add(0, 1, 32'h1F,       0, 32'h9,        1, 0, 0, 1); // 22 bin 21
        add(0, 0, 32'h0,        1, 32'd20,       1, 0, 0, 0); // 23 clr with bin 20: re-prime
        add(0, 0, 32'h0,        0, 32'd21,       1, 1, 0, 0); // 24 advance 21
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0); // 25 reset
        add(0, 1, 32'h80000000, 0, 32'h0,        0, 0, 0, 0); // 26 bin all-ones
        add(0, 1, 32'h0,        0, 32'h0,        0, 0, 0, 0); // 27 bin 0
        add(0, 0, 32'h0,        0, 32'hFFFFFFFF, 1, 0, 0, 0); // 28 prime all-ones
        add(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 0); // 29 wrap advance
        add(0, 1, 32'h80000000, 0, 32'h0,        1, 0, 0, 0); // 30 backwards
        add(0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0); // 31
        add(0, 0, 32'h0,        0, 32'hFFFFFFFF, 1, 0, 1, 1); // 32 step_err on -1
        add(0, 0, 32'h0,        0, 32'hFFFFFFFF, 1, 0, 0, 1); // 33
        add(0, 1, 32'h1,        0, 32'hFFFFFFFF, 1, 0, 0, 1); // 34 in flight
        add(0, 1, 32'h3,        0, 32'hFFFFFFFF, 1, 0, 0, 1); // 35 in flight
        add(1, 1, 32'h2,        0, 32'h0,        0, 0, 0, 0); // 36 mid-stream reset
        add(0, 1, 32'h1E,       0, 32'h0,        0, 0, 0, 0); // 37 bin 20
        add(0, 1, 32'h1F,       0, 32'h0,        0, 0, 0, 0); // 38 bin 21
        add(0, 0, 32'h0,        0, 32'd20,       1, 0, 0, 0); // 39 prime 20, no pulse
        add(0, 0, 32'h0,        0, 32'd21,       1, 1, 0, 0); // 40 advance 21
        add(0, 0, 32'h0,        1, 32'd21,       1, 0, 0, 0); // 41 clr with no sample
        add(0, 1, 32'h2,        0, 32'd21,       1, 0, 0, 0); // 42 bin 3
        add(0, 0, 32'h0,        0, 32'd21,       1, 0, 0, 0); // 43
        add(0, 0, 32'h0,        0, 32'h3,        1, 0, 0, 0); // 44 re-primed at 3, no pulse

        for (int i = 0; i < vecs.size(); i++) begin
            sb_t s;
            @(negedge clk);
            rst      = vecs[i].rst;
            in_valid = vecs[i].vld;
            in_grey  = vecs[i].grey;
            err_clr  = vecs[i].clr;
            s.due = n_edges + 1;
            s.row = i;
            s.e   = vecs[i].e;
            sb_q.push_back(s);
        end
        @(negedge clk);
        in_valid = 1'b0;
        err_clr  = 1'b0;
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/greycode_receiver.md
# greycode_receiver

Receiving end of the grey-coded counter path used by the FIFO flush logic. It passes an incoming grey-coded count through a configurable flop chain and decodes it to binary. It then checks that each new value is either the previous value or its single-step successor, modulo 2^WIDTH. The outputs are a registered binary count, a per-step advance pulse and skip-error flags for the flush/occupancy logic.

## Interface
Parameters:
- WIDTH, 32, bit width of the grey and binary counts (≥2)
- SYNC_STAGES, 2, number of capture flops ahead of the decode register (≥1)

Ports:
- clk  input  1  rising-edge clock; everything in this block runs on it
- rst  input  1  reset; one clock; reset is synchronous and active-high
- in_grey  input  WIDTH  grey-coded count from the counter
- in_valid  input  1  in_grey is meaningful this cycle
- err_clr  input  1  clears the sticky error and re-primes the tracker
- out_bin  output  WIDTH  last accepted binary count
- out_valid  output  1  out_bin holds at least one decoded sample
- advance  output  1  one-cycle pulse: the accepted sample is previous+1
- step_err  output  1  one-cycle pulse: the sample skipped or went backwards
- err_sticky  output  1  latched step_err; held until err_clr or rst

## Operation
- Capture chain: SYNC_STAGES flops, each WIDTH+1 bits wide (grey + valid). The chain shifts every cycle regardless of in_valid.
- Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i], computed combinationally from the last chain stage.
- Step compare: delta = bin − prev, a WIDTH-bit subtraction that wraps modulo 2^WIDTH. prev is out_bin.
- State machine, updated only when the last chain stage is valid:
  - UNPRIMED (reset state): load out_bin = bin, set out_valid = 1, go to TRACKING. No check is done, and advance/step_err stay 0.
  - TRACKING:
    - delta == 0: hold, no pulse.
    - delta == 1: load out_bin, pulse advance.
    - Any other delta: load out_bin, pulse step_err, set err_sticky, go to ERROR.
  - ERROR: out_bin keeps loading every valid sample. advance and step_err are never asserted. Stay in ERROR until err_clr.
- err_clr (any state): clear err_sticky and go to UNPRIMED. If a valid sample decodes in the same cycle, that sample is the priming sample: it loads out_bin, gives no pulse, and the next state is TRACKING. err_clr has priority over the step check.
- Wrap-around: bin all-ones → 0 is delta 1, which is a legal advance. For example, with WIDTH=32, grey 0x80000000 → grey 0x00000000.
- Invalid samples (valid bit 0 at the last stage) change nothing: out_bin, state and flags hold, and pulses are 0.

## Timing
- in_grey/in_valid sampled at edge k reach out_bin/advance/step_err right after edge k+SYNC_STAGES. With the default, that is a 2-cycle latency.
- advance and step_err are registered, last exactly one cycle per accepted sample, and are never both high.
- err_sticky rises in the same cycle as step_err. It falls on the cycle after the edge where err_clr is sampled high.
- Values after any edge with rst=1:
  - all chain flops = 0
  - out_bin = 0, out_valid = 0, advance = 0, step_err = 0, err_sticky = 0
  - state = UNPRIMED
- rst overrides everything, including in-flight chain samples and err_clr. Samples already inside the chain when rst is applied are discarded.
- Back-to-back valid samples are accepted one per cycle with no bubbles.

## Test plan
- Reset then prime, WIDTH=32, SYNC_STAGES=2: drive grey 0x7 (bin 5) valid at edge k. Required: out_bin=5 and out_valid=1 after edge k+2; advance=0 and step_err=0.
- Single steps: after priming at 5, drive grey 0x5 then grey 0x4. Required: out_bin 6 then 7 on consecutive cycles, each with a one-cycle advance pulse; no errors.
- Wrap: prime with grey 0x80000000 (bin 0xFFFFFFFF), then drive grey 0x0. Required: out_bin=0, advance pulse, step_err=0.
- Skip and clear: prime at grey 0x7 (bin 5), drive grey 0x4 (bin 7). Required: step_err pulse, err_sticky=1, out_bin=7. Then drive grey 0xC (bin 8): no advance pulse. Then assert err_clr together with a sample decoding to bin 20: err_sticky=0, out_bin=20, no pulse; the next bin 21 gives an advance pulse.
- Holds and gaps: repeat the same grey value and interleave in_valid=0 cycles. Required: no pulses and out_bin unchanged. A sample with in_valid=0 whose in_grey is a skipped value is ignored.
- Mid-stream reset: assert rst while two valid samples are in the chain. Required: all outputs 0 the next cycle, and neither in-flight sample appears at the outputs. The first valid sample after reset primes with no pulse.
